logic_arbiter: RTL and testbench



---
 rtl/logic_arbiter.sv | 157 +++++++++++++++
 tb/tb_logic_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : logic_arbiter
// Purpose  : Shares one bitwise logic unit (AND/OR/XOR/NOR) between two
//            requesters with round-robin arbitration. The granted operation is
//            computed and captured in a single output register, which is
//            drained through a valid/ready handshake. Grants are counted per
//            requester for debug.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            reqN_valid/op/a/b   - request N operation and operands (N=0,1)
//            reqN_ready          - request N granted this cycle (combinational)
//            out_valid/out_ready - result handshake
//            out_data/id/zero    - registered result, source, zero flag
//            cnt0, cnt1          - wrapping grant counters
// Revision : 1.0 - initial release
// ============================================================================
module logic_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_id,
    output logic             out_zero,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    localparam logic [1:0] C_OP_AND = 2'b00;
    localparam logic [1:0] C_OP_OR  = 2'b01;
    localparam logic [1:0] C_OP_XOR = 2'b10;

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   data_q;
    logic               id_q;
    logic               zero_q;
    logic               last_grant_q;
    logic [CNT_W-1:0]   cnt0_q;
    logic [CNT_W-1:0]   cnt1_q;

    logic               free;
    logic               grant0;
    logic               grant1;
    logic               xfer0;
    logic               xfer1;
    logic               xfer_any;
    logic [1:0]         sel_op;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic [WIDTH-1:0]   result_d;

    // The slot can accept a new result when empty or when the current one
    // leaves this cycle.
    assign free = (state_q == S_EMPTY) || out_ready;

    // On contention the requester that did not win last time is chosen.
    assign grant0 = req0_valid && (!req1_valid || last_grant_q);
    assign grant1 = req1_valid && (!req0_valid || !last_grant_q);

    assign req0_ready = free && grant0;
    assign req1_ready = free && grant1;

    assign xfer0    = req0_valid && req0_ready;
    assign xfer1    = req1_valid && req1_ready;
    assign xfer_any = xfer0 || xfer1;

    // Operand mux feeds the single shared logic unit.
    always_comb begin
        sel_op = req0_op;
        sel_a  = req0_a;
        sel_b  = req0_b;
        if (xfer1) begin
            sel_op = req1_op;
            sel_a  = req1_a;
            sel_b  = req1_b;
        end
    end

    always_comb begin
        result_d = '0;
        case (sel_op)
            C_OP_AND: result_d = sel_a & sel_b;
            C_OP_OR:  result_d = sel_a | sel_b;
            C_OP_XOR: result_d = sel_a ^ sel_b;
            default:  result_d = ~(sel_a | sel_b);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_EMPTY;
            data_q       <= '0;
            id_q         <= 1'b0;
            zero_q       <= 1'b0;
            // Pretend requester 1 won last so requester 0 wins first contention.
            last_grant_q <= 1'b1;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (xfer_any) begin
                        state_q <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (out_ready && !xfer_any) begin
                        state_q <= S_EMPTY;
                    end
                end
                default: state_q <= S_EMPTY;
            endcase

            // A new result overwrites the register; a plain drain keeps the
            // last values visible.
            if (xfer_any) begin
                data_q       <= result_d;
                id_q         <= xfer1;
                zero_q       <= (result_d == '0);
                last_grant_q <= xfer1;
            end
            if (xfer0) begin
                cnt0_q <= cnt0_q + 1'b1;
            end
            if (xfer1) begin
                cnt1_q <= cnt1_q + 1'b1;
            end
        end
    end

    assign out_valid = (state_q == S_FULL);
    assign out_data  = data_q;
    assign out_id    = id_q;
    assign out_zero  = zero_q;
    assign cnt0      = cnt0_q;
    assign cnt1      = cnt1_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_arbiter
// Purpose  : Self-checking bench for logic_arbiter. Directed scenarios plus a
//            randomized run, all compared against a behavioural model of the
//            arbiter kept in the bench.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_arbiter;

    localparam int WIDTH = 32;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             req0_valid;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_ready;
    logic             req1_valid;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_id;
    logic             out_zero;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    int n_checks;
    int n_err;

    // Behavioural model state
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_id;
    logic             m_zero;
    int               m_last;     // requester that won the latest grant
    int               m_cnt0;
    int               m_cnt1;
    int               m_winner;   // -1 none, else requester granted in the last tick

    logic_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_zero   (out_zero),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] ref_op(input logic [1:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            case (op)
                2'd0: r[i] = a[i] & b[i];
                2'd1: r[i] = a[i] | b[i];
                2'd2: r[i] = a[i] ^ b[i];
                default: r[i] = !(a[i] | b[i]);
            endcase
        end
        return r;
    endfunction

    // Which requester the rules grant right now (-1 for none).
    function automatic int exp_winner();
        if (m_valid && !out_ready) return -1;
        if (req0_valid && req1_valid) return (m_last == 0) ? 1 : 0;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_valid  = 1'b0;
        m_data   = '0;
        m_id     = 1'b0;
        m_zero   = 1'b0;
        m_last   = 1;
        m_cnt0   = 0;
        m_cnt1   = 0;
        m_winner = -1;
    endtask

    // Advance one clock: inputs are stable from the previous negedge, so the
    // model evaluates the grant before the edge and the bench resumes on the
    // following negedge to sample outputs.
    task automatic tick();
        int w;
        w = exp_winner();
        @(posedge clk);
        m_winner = w;
        if (rst) begin
            model_reset();
        end else if (w == 0) begin
            m_data  = ref_op(req0_op, req0_a, req0_b);
            m_id    = 1'b0;
            m_zero  = (m_data == 0);
            m_valid = 1'b1;
            m_last  = 0;
            m_cnt0  = (m_cnt0 + 1) % 256;
        end else if (w == 1) begin
            m_data  = ref_op(req1_op, req1_a, req1_b);
            m_id    = 1'b1;
            m_zero  = (m_data == 0);
            m_valid = 1'b1;
            m_last  = 1;
            m_cnt1  = (m_cnt1 + 1) % 256;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_op = 2'd0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = 2'd0; req1_a = '0; req1_b = '0;
        out_ready  = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({out_valid, out_data, out_id, out_zero, cnt0, cnt1} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got valid=%b data=%h id=%b zero=%b cnt0=%0d cnt1=%0d, want all 0",
                     out_valid, out_data, out_id, out_zero, cnt0, cnt1);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic_and();
        req0_valid = 1'b1; req0_op = 2'd0;
        req0_a = 32'hFFFF0000; req0_b = 32'h0F0F0F0F;
        #1;
        n_checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_err++;
            $display("FAIL and_ready: got r0=%b r1=%b, want r0=1 r1=0", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0F0F0000 || out_id !== 1'b0 ||
            out_zero !== 1'b0 || cnt0 !== 8'd1) begin
            n_err++;
            $display("FAIL and_result: got v=%b data=%h id=%b zero=%b cnt0=%0d, want v=1 data=0f0f0000 id=0 zero=0 cnt0=1",
                     out_valid, out_data, out_id, out_zero, cnt0);
        end
    endtask

    task automatic test_alternate();
        do_reset();
        req0_valid = 1'b1; req0_op = 2'd1; req0_a = 32'h1; req0_b = 32'h2;
        req1_valid = 1'b1; req1_op = 2'd3; req1_a = 32'h0; req1_b = 32'h0;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_checks++;
            if (req0_ready !== ((i % 2) == 0) || req1_ready !== ((i % 2) == 1)) begin
                n_err++;
                $display("FAIL alt_grant[%0d]: got r0=%b r1=%b, want r0=%0d r1=%0d",
                         i, req0_ready, req1_ready, (i % 2) == 0, (i % 2) == 1);
            end
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_id !== (i % 2) ||
                out_data !== (((i % 2) == 0) ? 32'h00000003 : 32'hFFFFFFFF)) begin
                n_err++;
                $display("FAIL alt_result[%0d]: got v=%b id=%b data=%h", i, out_valid, out_id, out_data);
            end
        end
        n_checks++;
        if (cnt0 !== 8'd4 || cnt1 !== 8'd4) begin
            n_err++;
            $display("FAIL alt_counts: got cnt0=%0d cnt1=%0d, want 4 4", cnt0, cnt1);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_xor_zero();
        req0_valid = 1'b1; req0_op = 2'd2; req0_a = 32'hA5A5A5A5; req0_b = 32'hA5A5A5A5;
        tick();
        req0_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0 || out_zero !== 1'b1) begin
            n_err++;
            $display("FAIL xor_zero: got v=%b data=%h zero=%b, want v=1 data=0 zero=1",
                     out_valid, out_data, out_zero);
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] held_data;
        logic             held_id;
        logic             held_zero;
        out_ready  = 1'b1;
        req0_valid = 1'b1; req0_op = 2'd1; req0_a = 32'h00F0; req0_b = 32'h0F00;
        tick();
        req0_valid = 1'b0;
        out_ready  = 1'b0;
        req1_valid = 1'b1; req1_op = 2'd0; req1_a = 32'hDEADBEEF; req1_b = 32'hFFFF00FF;
        held_data  = 32'h0FF0;
        held_id    = 1'b0;
        held_zero  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || out_valid !== 1'b1 ||
                out_data !== held_data || out_id !== held_id || out_zero !== held_zero) begin
                n_err++;
                $display("FAIL stall[%0d]: got r0=%b r1=%b v=%b data=%h id=%b zero=%b, want r=0 v=1 data=%h",
                         i, req0_ready, req1_ready, out_valid, out_data, out_id, out_zero, held_data);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (req1_ready !== 1'b1) begin
            n_err++;
            $display("FAIL release_ready: got r1=%b, want 1", req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hDEAD00EF || out_id !== 1'b1) begin
            n_err++;
            $display("FAIL drain_and_grant: got v=%b data=%h id=%b, want v=1 data=dead00ef id=1",
                     out_valid, out_data, out_id);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 32'hDEAD00EF) begin
            n_err++;
            $display("FAIL plain_drain: got v=%b data=%h, want v=0 data=dead00ef", out_valid, out_data);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req1_valid = 1'b1; req1_op = 2'd2; req1_a = 32'h1234; req1_b = 32'h4321;
        for (int i = 0; i < 256; i++) begin
            tick();
        end
        req1_valid = 1'b0;
        n_checks++;
        if (cnt1 !== 8'd0 || cnt0 !== 8'd0 || m_cnt1 != 0) begin
            n_err++;
            $display("FAIL cnt_wrap: got cnt0=%0d cnt1=%0d, want 0 0", cnt0, cnt1);
        end
        tick();
    endtask

    task automatic test_random();
        logic p0, p1;
        p0 = 1'b0; p1 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!p0 && $urandom_range(0, 2) != 0) begin
                p0 = 1'b1; req0_op = 2'($urandom_range(0, 3));
                req0_a = $urandom; req0_b = ($urandom_range(0, 7) == 0) ? req0_a : $urandom;
            end
            if (!p1 && $urandom_range(0, 2) != 0) begin
                p1 = 1'b1; req1_op = 2'($urandom_range(0, 3));
                req1_a = $urandom; req1_b = ($urandom_range(0, 7) == 0) ? ~req1_a : $urandom;
            end
            req0_valid = p0;
            req1_valid = p1;
            out_ready  = ($urandom_range(0, 3) != 0);
            #1;
            n_checks++;
            if (req0_ready !== (exp_winner() == 0) || req1_ready !== (exp_winner() == 1)) begin
                n_err++;
                $display("FAIL rand_ready[%0d]: got r0=%b r1=%b, want winner %0d",
                         i, req0_ready, req1_ready, exp_winner());
            end
            tick();
            if (m_winner == 0) p0 = 1'b0;
            if (m_winner == 1) p1 = 1'b0;
            n_checks++;
            if (out_valid !== m_valid || out_data !== m_data || out_id !== m_id ||
                out_zero !== m_zero || cnt0 !== CNT_W'(m_cnt0) || cnt1 !== CNT_W'(m_cnt1)) begin
                n_err++;
                $display("FAIL rand_out[%0d]: got v=%b d=%h id=%b z=%b c0=%0d c1=%0d, want v=%b d=%h id=%b z=%b c0=%0d c1=%0d",
                         i, out_valid, out_data, out_id, out_zero, cnt0, cnt1,
                         m_valid, m_data, m_id, m_zero, m_cnt0, m_cnt1);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready  = 1'b1;
        req1_valid = 1'b1; req1_op = 2'd1; req1_a = 32'h5; req1_b = 32'h8;
        tick();
        out_ready  = 1'b0;
        req0_valid = 1'b1; req0_op = 2'd0; req0_a = 32'hFFFF; req0_b = 32'hFF;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || cnt0 !== 8'd0 || cnt1 !== 8'd0 || out_data !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid: got v=%b cnt0=%0d cnt1=%0d data=%h, want 0", out_valid, cnt0, cnt1, out_data);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready  = 1'b1;
        req1_valid = 1'b1;
        #1;
        n_checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_first_win: got r0=%b r1=%b, want r0=1 r1=0", req0_ready, req1_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_id !== 1'b0 || out_data !== 32'hFF || cnt0 !== 8'd1 || cnt1 !== 8'd0) begin
            n_err++;
            $display("FAIL reset_first_result: got v=%b id=%b data=%h c0=%0d c1=%0d, want 1 0 ff 1 0",
                     out_valid, out_id, out_data, cnt0, cnt1);
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        model_reset();
        test_reset();
        test_basic_and();
        test_alternate();
        test_xor_zero();
        test_backpressure();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
